// File: rtl/fitbit_display_scheduler_pkg.sv
// Shared definitions for the display scheduler: mode encodings, display limits
// and decimal-point patterns.
package fitbit_display_scheduler_pkg;

  typedef enum logic [1:0] {
    MODE_STEPS  = 2'd0,
    MODE_DIST   = 2'd1,
    MODE_ACTIVE = 2'd2,
    MODE_ALERT  = 2'd3
  } mode_t;

  localparam logic [13:0] DISP_MAX = 14'd9999;

  localparam logic [3:0] DP_NONE  = 4'b0000;
  localparam logic [3:0] DP_DIST  = 4'b0010;
  localparam logic [3:0] DP_ALERT = 4'b1111;

  // ALERT never appears in the rotation, so it falls back to STEPS.
  function automatic mode_t next_rotation(input mode_t m);
    case (m)
      MODE_STEPS: return MODE_DIST;
      MODE_DIST:  return MODE_ACTIVE;
      default:    return MODE_STEPS;
    endcase
  endfunction

endpackage

// File: rtl/fitbit_sec_tick.sv
// Free-running one-second timebase: tick is high for the single cycle in which
// the cycle counter wraps back to zero.
module fitbit_sec_tick #(
  parameter int SEC_CYCLES = 100000000
) (
  input  logic clk100Mhz,
  input  logic rst,
  output logic tick
);

  localparam int CW = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SEC_CYCLES - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk100Mhz or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/fitbit_display_scheduler.sv
// Rotates the 4-digit display between steps, distance and active seconds,
// with an overflow ALERT mode that preempts the rotation and then returns.
module fitbit_display_scheduler
  import fitbit_display_scheduler_pkg::*;
#(
  parameter int SEC_CYCLES = 100000000,
  parameter int DWELL_SECS = 2,
  parameter int ACT_THRESH = 32
) (
  input  logic        clk100Mhz,
  input  logic        rst,
  input  logic        stepPulse,
  input  logic [13:0] stepCount,
  input  logic [3:0]  distance,
  input  logic        OFLOW,
  input  logic        advanceReq,
  input  logic        holdReq,
  output logic [1:0]  modeSel,
  output logic [13:0] dispValue,
  output logic [3:0]  dpMask,
  output logic        modeChange
);

  localparam int DW = (DWELL_SECS > 1) ? $clog2(DWELL_SECS + 1) : 1;
  localparam int WW = (ACT_THRESH > 1) ? $clog2(ACT_THRESH + 1) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_SECS - 1);
  localparam logic [WW-1:0] ACT_MAX    = WW'(ACT_THRESH);

  logic          tick;
  mode_t         mode;
  mode_t         prev_mode;
  mode_t         saved_mode;
  mode_t         leave_target;
  logic [DW-1:0] dwell;
  logic [WW-1:0] win_count;
  logic [13:0]   active_secs;
  logic          oflow_q;
  logic          oflow_rise;
  logic          armed;
  logic [13:0]   disp_next;
  logic [3:0]    dp_next;

  fitbit_sec_tick #(.SEC_CYCLES(SEC_CYCLES)) u_sec_tick (
    .clk100Mhz (clk100Mhz),
    .rst       (rst),
    .tick      (tick)
  );

  assign oflow_rise   = OFLOW && !oflow_q;
  assign leave_target = (mode == MODE_ALERT) ? saved_mode : next_rotation(mode);
  assign modeSel      = mode;

  // A pulse landing on the tick cycle belongs to the window that tick opens.
  always_ff @(posedge clk100Mhz or posedge rst) begin
    if (rst) begin
      win_count   <= '0;
      active_secs <= '0;
    end else if (tick) begin
      if (win_count >= ACT_MAX && active_secs != DISP_MAX) begin
        active_secs <= active_secs + 14'd1;
      end
      win_count <= stepPulse ? WW'(1) : '0;
    end else if (stepPulse && win_count != ACT_MAX) begin
      win_count <= win_count + WW'(1);
    end
  end

  // Priority: overflow rise, then user advance, then dwell expiry on tick.
  always_ff @(posedge clk100Mhz or posedge rst) begin
    if (rst) begin
      mode       <= MODE_STEPS;
      saved_mode <= MODE_STEPS;
      dwell      <= '0;
      oflow_q    <= 1'b0;
    end else begin
      oflow_q <= OFLOW;
      if (oflow_rise) begin
        if (mode != MODE_ALERT) begin
          saved_mode <= mode;
        end
        mode  <= MODE_ALERT;
        dwell <= '0;
      end else if (advanceReq) begin
        mode  <= leave_target;
        dwell <= '0;
      end else if (tick && (mode == MODE_ALERT || !holdReq)) begin
        if (dwell == DWELL_LAST) begin
          mode  <= leave_target;
          dwell <= '0;
        end else begin
          dwell <= dwell + DW'(1);
        end
      end
    end
  end

  always_comb begin
    disp_next = DISP_MAX;
    dp_next   = DP_NONE;
    case (mode)
      MODE_STEPS: begin
        disp_next = (OFLOW || stepCount > DISP_MAX) ? DISP_MAX : stepCount;
      end
      MODE_DIST: begin
        disp_next = {10'd0, distance} * 14'd5;
        dp_next   = DP_DIST;
      end
      MODE_ACTIVE: begin
        disp_next = active_secs;
      end
      default: begin
        disp_next = DISP_MAX;
        dp_next   = DP_ALERT;
      end
    endcase
  end

  // armed holds the display steady for the first cycle out of reset.
  always_ff @(posedge clk100Mhz or posedge rst) begin
    if (rst) begin
      prev_mode  <= MODE_STEPS;
      modeChange <= 1'b0;
      dispValue  <= '0;
      dpMask     <= DP_NONE;
      armed      <= 1'b0;
    end else begin
      armed      <= 1'b1;
      prev_mode  <= mode;
      modeChange <= (mode != prev_mode);
      if (armed) begin
        dispValue <= disp_next;
        dpMask    <= dp_next;
      end
    end
  end

endmodule

// File: doc/fitbit_display_scheduler.md
FITBIT_DISPLAY_SCHEDULER -- requirements
Module: fitbit_display_scheduler

Interface
REQ-001 Parameter SEC_CYCLES, default 100000000: clk100Mhz cycles per one-second tick.
REQ-002 Parameter DWELL_SECS, default 2: seconds each display mode is shown.
REQ-003 Parameter ACT_THRESH, default 32: step pulses within one second that make that second "active".
REQ-004 clk100Mhz  in  1  sole clock; all logic rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 stepPulse  in  1  one-cycle pulse per counted step from the tracker datapath.
REQ-007 stepCount  in  14  running step total from the tracker.
REQ-008 distance  in  4  distance in half-mile units from the tracker.
REQ-009 OFLOW  in  1  tracker overflow flag, level.
REQ-010 advanceReq  in  1  debounced one-cycle user request to skip to the next mode.
REQ-011 holdReq  in  1  level; freezes rotation while high.
REQ-012 modeSel  out  2  current mode: 0 STEPS, 1 DIST, 2 ACTIVE, 3 ALERT.
REQ-013 dispValue  out  14  binary value 0..9999 for the 4-digit display.
REQ-014 dpMask  out  4  decimal-point enables, bit0 = rightmost digit.
REQ-015 modeChange  out  1  one-cycle pulse in the cycle after modeSel changes.

Function
REQ-016 Second tick: counter 0..SEC_CYCLES-1, tick asserted one cycle on wrap; free-running, unaffected by holdReq.
REQ-017 Activity window: stepPulse counted per second, saturating at ACT_THRESH; on tick, if count >= ACT_THRESH, activeSeconds increments (saturate 9999); window count clears on tick; stepPulse coincident with tick counts in the new window.
REQ-018 Rotation FSM: STEPS -> DIST -> ACTIVE -> STEPS; dwell counter increments on tick, transition when it reaches DWELL_SECS, dwell then clears.
REQ-019 holdReq high: dwell counter frozen, rotation stops; advanceReq still honoured.
REQ-020 advanceReq in a rotation state: transition to next rotation state on the next edge, dwell cleared; coincident tick ignored for dwell.
REQ-021 OFLOW rising edge (registered compare, 0 then 1): save current rotation state, enter ALERT, dwell cleared; OFLOW held high does not re-trigger.
REQ-022 ALERT exits after DWELL_SECS ticks (holdReq ignored) or immediately on advanceReq, returning to the saved state with dwell cleared.
REQ-023 OFLOW rise and advanceReq in same cycle: ALERT wins, advanceReq dropped.
REQ-024 OFLOW rise while in ALERT: dwell restarts, saved state unchanged.
REQ-025 dispValue/dpMask registered, one-cycle latency from mode or input change: STEPS = min(stepCount, 9999), dp 0000; DIST = distance*5 (tenths of a mile), dp 0010; ACTIVE = activeSeconds, dp 0000; ALERT = 9999, dp 1111.
REQ-026 STEPS shows 9999 whenever OFLOW is high.

Reset
REQ-027 rst asserted: modeSel 0 (STEPS), dispValue 0, dpMask 0000, modeChange 0, saved state STEPS, all counters and activeSeconds 0, OFLOW history 0.
REQ-028 Reset mid-ALERT or mid-dwell discards all progress; OFLOW already high at deassertion triggers ALERT one cycle later (history reset to 0).
REQ-029 No output changes in the first cycle after deassertion, other than REQ-028.

Structure
REQ-030 Shared package holds mode encodings (STEPS/DIST/ACTIVE/ALERT), DISP_MAX = 9999 and dp pattern constants.
REQ-031 One sub-module, fitbit_sec_tick, implements REQ-016 and exports tick; everything else lives in the top.

Verification (SEC_CYCLES=10, DWELL_SECS=2, ACT_THRESH=3)
REQ-032 Reset, idle 60 cycles -> modeSel 0,1,2,0 changing every 20 cycles, modeChange pulsed at each change.
REQ-033 stepCount=12000, OFLOW=0 in STEPS -> dispValue 9999; distance=3 in DIST -> dispValue 15, dpMask 0010.
REQ-034 3 stepPulses in one second, then 2 in the next -> activeSeconds 1, ACTIVE shows 1.
REQ-035 OFLOW rises in DIST -> modeSel 3, dispValue 9999, dpMask 1111 for 20 cycles, then modeSel 1.
REQ-036 holdReq high 50 cycles in STEPS -> modeSel stays 0; advanceReq pulse -> modeSel 1 next cycle.
REQ-037 OFLOW rise and advanceReq same cycle in STEPS -> ALERT; rst mid-ALERT -> modeSel 0, all outputs 0.
